// File: rtl/timer_multi.sv
// rtl/timer_multi.sv - NUM_CH independent programmable one-shot/periodic timers
//
// Purpose:
//   Each channel counts down a latched period and emits a one-cycle expiry
//   pulse. Channels run in one-shot or periodic mode and can be restarted or
//   aborted at any time. Control FSMs issue the START/STOP strobes and use
//   PULSE as a timeout or tick event.
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_i       asynchronous reset, active-high
//   start_i     per-channel start/restart strobe
//   stop_i      per-channel abort strobe (wins over start_i)
//   periodic_i  per-channel mode, sampled with start_i (1 = periodic)
//   period_i    per-channel period, channel i at [i*WIDTH +: WIDTH]
//   pulse_o     per-channel one-cycle expiry pulse, registered
//   busy_o      per-channel RUN indication, registered
//
// Optional feature macro: PRESCALE_EN
//   Defined: a shared divide-by-PRESCALE_DIV tick gates counting and expiry.
//   Undefined: every clock edge is a counting edge.

module timer_multi #(
    parameter int NUM_CH       = 4,
    parameter int WIDTH        = 21,
    parameter int PRESCALE_DIV = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_CH-1:0]       start_i,
    input  logic [NUM_CH-1:0]       stop_i,
    input  logic [NUM_CH-1:0]       periodic_i,
    input  logic [NUM_CH*WIDTH-1:0] period_i,
    output logic [NUM_CH-1:0]       pulse_o,
    output logic [NUM_CH-1:0]       busy_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    if (NUM_CH < 1 || PRESCALE_DIV < 2) begin : g_bad_param
        $error("timer_multi: NUM_CH must be >= 1 and PRESCALE_DIV >= 2");
    end

    // Shared counting-edge enable.
    logic tick;

`ifdef PRESCALE_EN
    localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE_DIV - 1);

    logic [PW-1:0] pre_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre_q <= '0;
        end else if (pre_q == PRE_LAST) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

    assign tick = (pre_q == PRE_LAST);
`else
    assign tick = 1'b1;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_e           state_q, state_d;
        logic [WIDTH-1:0] rem_q, rem_d;
        logic [WIDTH-1:0] n_q, n_d;
        logic [WIDTH-1:0] period_slice;
        logic [WIDTH-1:0] start_n;
        logic             mode_q, mode_d;
        logic             pulse_q, pulse_d;
        logic             busy_q;

        assign period_slice = period_i[i*WIDTH +: WIDTH];
        // A zero period behaves as a period of one.
        assign start_n = (period_slice == '0) ? ONE : period_slice;

        always_comb begin
            state_d = state_q;
            rem_d   = rem_q;
            n_d     = n_q;
            mode_d  = mode_q;
            pulse_d = 1'b0;
            // Priority: stop, then (re)start, then counting. A restart or stop
            // on the expiry edge therefore suppresses that pulse.
            if (stop_i[i]) begin
                state_d = ST_IDLE;
            end else if (start_i[i]) begin
                n_d     = start_n;
                mode_d  = periodic_i[i];
                rem_d   = start_n - ONE;
                state_d = ST_RUN;
            end else if (state_q == ST_RUN && tick) begin
                if (rem_q != '0) begin
                    rem_d = rem_q - ONE;
                end else begin
                    pulse_d = 1'b1;
                    if (mode_q) begin
                        rem_d = n_q - ONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q <= ST_IDLE;
                rem_q   <= '0;
                n_q     <= '0;
                mode_q  <= 1'b0;
                pulse_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                rem_q   <= rem_d;
                n_q     <= n_d;
                mode_q  <= mode_d;
                pulse_q <= pulse_d;
                busy_q  <= (state_d == ST_RUN);
            end
        end

        assign pulse_o[i] = pulse_q;
        assign busy_o[i]  = busy_q;
    end

endmodule

// File: doc/timer_multi.md
Name: timer_multi

Overview:
- Parametrised successor to the single-channel one-shot timer.
- NUM_CH independent channels, each with a run-time programmable period, one-shot or periodic mode, abort (STOP) and restart.
- Each channel emits a one-cycle PULSE on expiry.
- Sits beside the control FSMs, which issue START/STOP strobes and consume PULSE as timeout/tick events.

Parameters:
NUM_CH, 4, number of independent timer channels (>=1)
WIDTH, 21, width of each channel's period and down-counter
PRESCALE_DIV, 4, clock divide ratio for the shared tick (>=2); used only when PRESCALE_EN is defined

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  asynchronous reset, active-high
START  input  NUM_CH  per-channel start/restart strobe, sampled each edge
STOP  input  NUM_CH  per-channel abort strobe
PERIODIC  input  NUM_CH  per-channel mode, sampled with START: 1 = periodic, 0 = one-shot
PERIOD  input  NUM_CH*WIDTH  per-channel period N; channel i uses bits [i*WIDTH +: WIDTH], sampled with START
PULSE  output  NUM_CH  one-cycle expiry pulse, registered
BUSY  output  NUM_CH  channel in RUN state, registered

Behaviour:
Reset:
- One clock, CLK. Reset is asynchronous and active-high (RST).
- While RST is high: all channels IDLE; PULSE=0, BUSY=0; internal counters, latched period and latched mode = 0; prescaler counter = 0.

Per-channel state machine (IDLE, RUN). The remaining-count register rem is WIDTH bits.
- IDLE + START (and not STOP) at edge E0:
  - latch N = PERIOD slice and the mode; N=0 is treated as N=1.
  - rem <= N-1; state <= RUN.
- RUN, each counting edge:
  - rem != 0: rem <= rem-1.
  - rem == 0: PULSE <= 1.
    - periodic: rem <= N-1 and stay in RUN.
    - one-shot: state <= IDLE.
- Latency: PULSE is high exactly between edges E_N and E_N+1.
  - Periodic: further pulses between E_kN and E_kN+1 for k = 2, 3, …
- BUSY rises after E0.
  - One-shot: BUSY falls at E_N, the same edge PULSE rises.
  - Periodic: BUSY stays high until STOP.
- PULSE defaults to 0 every cycle; it is never high for two consecutive cycles unless N=1 periodic, where it stays high continuously.

Boundary conditions:
- START in RUN: restart. Re-latch PERIOD and mode, rem <= N-1. If rem==0 at the same edge, the restart wins and no PULSE is issued.
- STOP in RUN: state <= IDLE, BUSY <= 0. No PULSE, even if rem==0 at that edge.
- STOP in IDLE: ignored.
- START and STOP at the same edge: STOP wins; channel ends IDLE with no latch.
- PERIOD/PERIODIC changes while in RUN: no effect until the next START.
- N = 2^WIDTH-1: no overflow, because the counter counts down only.
- Reset mid-count: immediate return to IDLE, outputs 0, no pulse after release.
- Channels are fully independent; simultaneous events on different channels never interact.

Optional Feature:
Macro: PRESCALE_EN
- Defined:
  - A shared counter runs 0..PRESCALE_DIV-1 continuously from reset release; tick = (count == PRESCALE_DIV-1).
  - Channel rem decrement and expiry evaluation happen only on edges where tick=1.
  - START, STOP and the latching of PERIOD/PERIODIC act on any edge.
  - PULSE remains one CLK cycle wide.
  - Expiry occurs on the N-th tick edge after E0, so latency in CLK cycles is between (N-1)*DIV+1 and N*DIV.
- Not defined: tick is constant 1, PRESCALE_DIV is unused, and timing is exactly as stated in Behaviour.

Test Plan:
1. Reset then one-shot: ch0 PERIOD=5, PERIODIC=0, START pulse at E0 -> BUSY[0]=1 after E0; PULSE[0]=1 only between E5 and E6; BUSY[0]=0 after E5; no further pulses over 20 cycles.
2. Periodic: ch1 PERIOD=3, PERIODIC=1 -> PULSE[1] high after E3, E6, E9; STOP at E10 -> BUSY[1]=0 after E10; no pulse at E12.
3. Abort/restart: ch2 PERIOD=4, START at E0, second START with PERIOD=6 at E4 (the expiry edge) -> no pulse at E4; PULSE[2] after E10. Repeat with STOP at E4 -> no pulse ever.
4. Edge values: PERIOD=0 and PERIOD=1 -> both pulse after E1. Periodic with PERIOD=1 -> PULSE continuously high until STOP. START+STOP same edge in IDLE -> BUSY stays 0.
5. Parallel channels plus reset: all 4 channels started with PERIOD=2,3,4,5 on the same edge -> pulses after E2..E5 respectively. Assert RST mid-run at E3 -> PULSE/BUSY drop to 0 asynchronously; no pulses after release.
6. PRESCALE_EN, PRESCALE_DIV=4, PERIOD=2 -> PULSE within 5..8 cycles of START; PULSE exactly one cycle wide; START while prescaler count=1 is still latched.
